// File: rtl/dispatch_pkg.sv
// Shared definitions for the 8-way dispatcher.
// Holds the channel count, the select width, the mode encodings and the
// holding-register state encoding used by the dispatcher and its helpers.
package dispatch_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_DIR = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/dmux8way.sv
// 1-bit, 8-way demultiplexor (Hack DMux8Way).
// Ports:
//   in_i       : bit to steer
//   sel_i[2:0] : output that receives in_i
//   a_o..h_o   : outputs for sel 0..7; the unselected outputs are 0
module dmux8way (
    input  logic       in_i,
    input  logic [2:0] sel_i,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       d_o,
    output logic       e_o,
    output logic       f_o,
    output logic       g_o,
    output logic       h_o
);

    assign a_o = in_i & (sel_i == 3'd0);
    assign b_o = in_i & (sel_i == 3'd1);
    assign c_o = in_i & (sel_i == 3'd2);
    assign d_o = in_i & (sel_i == 3'd3);
    assign e_o = in_i & (sel_i == 3'd4);
    assign f_o = in_i & (sel_i == 3'd5);
    assign g_o = in_i & (sel_i == 3'd6);
    assign h_o = in_i & (sel_i == 3'd7);

endmodule

// File: rtl/rr_pick8.sv
// Round-robin picker over eight channels (combinational).
// Ports:
//   mask_i[7:0] : channels that are eligible
//   ptr_i[2:0]  : channel picked last time; the scan starts just after it
//   pick_o[2:0] : first eligible channel at ptr_i+1, ptr_i+2, ... (cyclic)
//   any_o       : at least one channel is eligible (pick_o valid)
module rr_pick8
    import dispatch_pkg::*;
(
    input  logic [NCH-1:0]   mask_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] pick_o,
    output logic             any_o
);

    logic [SEL_W-1:0] idx_s;

    // Cyclic scan; the 3-bit add wraps 7->0 and offset 8 lands back on ptr_i.
    always_comb begin
        pick_o = 3'd0;
        any_o  = 1'b0;
        idx_s  = 3'd0;
        for (int k = 1; k <= NCH; k++) begin
            idx_s = ptr_i + k[SEL_W-1:0];
            if (!any_o && mask_i[idx_s]) begin
                pick_o = idx_s;
                any_o  = 1'b1;
            end else begin
                any_o  = any_o;
            end
        end
    end

endmodule

// File: rtl/dmux8way_dispatcher.sv
// One-word dispatcher sharing a producer stream among eight consumers.
// A word accepted over in_valid/in_ready is held in a single register and
// offered to exactly one consumer (dest) until that consumer takes it.
// The destination is picked round-robin over en_mask (mode 0) or taken from
// in_sel (mode 1); a directed word aimed at a disabled channel is discarded
// and reported with a one-cycle drop pulse.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   mode                : 0 = round-robin, 1 = directed by in_sel
//   en_mask[7:0]        : channels allowed to receive
//   in_data/in_sel      : producer word and its directed channel
//   in_valid/in_ready   : producer handshake
//   out_data            : held word, broadcast to all consumers
//   out_valid[7:0]      : one-hot valid for channel dest, 0 when empty
//   out_ready[7:0]      : consumer ready, only out_ready[dest] matters
//   dest, busy          : channel of the held word, holding register full
//   drop                : directed word to a disabled channel was discarded
//   count               : number of delivered words (wrapping)
module dmux8way_dispatcher
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [NCH-1:0]    en_mask,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [SEL_W-1:0]  dest,
    output logic              busy,
    output logic              drop,
    output logic [CNT_W-1:0]  count
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   dest_q, dest_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               drop_q, drop_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [SEL_W-1:0]   rr_pick_s;
    logic               rr_any_s;
    logic               deliver_s;
    logic               accept_s;
    logic               keep_s;
    logic [SEL_W-1:0]   target_s;

    rr_pick8 u_pick (
        .mask_i (en_mask),
        .ptr_i  (rr_ptr_q),
        .pick_o (rr_pick_s),
        .any_o  (rr_any_s)
    );

    dmux8way u_fanout (
        .in_i  (busy),
        .sel_i (dest_q),
        .a_o   (out_valid[0]),
        .b_o   (out_valid[1]),
        .c_o   (out_valid[2]),
        .d_o   (out_valid[3]),
        .e_o   (out_valid[4]),
        .f_o   (out_valid[5]),
        .g_o   (out_valid[6]),
        .h_o   (out_valid[7])
    );

    assign busy     = (state_q == ST_FULL);
    assign out_data = data_q;
    assign dest     = dest_q;
    assign drop     = drop_q;
    assign count    = count_q;

    assign deliver_s = busy & out_ready[dest_q];
    // Round-robin with nothing enabled stalls the producer; rr_any_s is
    // exactly en_mask != 0.
    assign in_ready  = (~busy | deliver_s) & ~((mode == MODE_RR) & ~rr_any_s);
    assign accept_s  = in_valid & in_ready;
    // A directed word survives only if its channel is enabled.
    assign keep_s    = accept_s & ((mode == MODE_RR) | en_mask[in_sel]);
    assign target_s  = (mode == MODE_RR) ? rr_pick_s : in_sel;

    // Next-state computation for the holding register and bookkeeping.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dest_d   = dest_q;
        rr_ptr_d = rr_ptr_q;
        drop_d   = accept_s & ~keep_s;
        count_d  = deliver_s ? (count_q + CNT_W'(1'b1)) : count_q;

        if (keep_s) begin
            state_d = ST_FULL;
            data_d  = in_data;
            dest_d  = target_s;
        end else if (deliver_s) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end

        if (accept_s && (mode == MODE_RR)) begin
            rr_ptr_d = rr_pick_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers; rr_ptr resets to 7 so the first round-robin pick is 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            data_q   <= {WIDTH{1'b0}};
            dest_q   <= 3'd0;
            rr_ptr_q <= 3'd7;
            drop_q   <= 1'b0;
            count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dest_q   <= dest_d;
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
        end
    end

endmodule
